// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: streams a block of words from a 1-cycle imem
// into a small prefetch FIFO and hands them to the decoder on valid/ready.
module inst_fetch_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int OPCODE_W   = 4,
    parameter logic [OPCODE_W-1:0] OP_BLOCK_END = 4'hF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  imem_read_req,
    output logic [ADDR_WIDTH-1:0] imem_read_addr,
    input  logic [DATA_WIDTH-1:0] imem_read_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_addr
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_q, rd_q;
    logic [CW-1:0]         count_q, count_d;

    logic       pop, push, head_end, ret_end;
    logic [CW:0] occ;

    always_comb begin
        inst_valid = (count_q != '0);
        inst_data  = fifo_data_q[rd_q];
        inst_addr  = fifo_addr_q[rd_q];
        pop        = inst_valid && inst_ready;
        head_end   = (inst_data[DATA_WIDTH-1 -: OPCODE_W] == OP_BLOCK_END);
        ret_end    = (imem_read_data[DATA_WIDTH-1 -: OPCODE_W] == OP_BLOCK_END);
        // Returns landing after the end word (state already DRAIN) are dropped.
        push       = inflight_q && (state_q == FETCH);
        occ        = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
        imem_read_req  = (state_q == FETCH) && !abort && (occ < (CW+1)'(FIFO_DEPTH));
        imem_read_addr = imem_read_req ? ptr_q : '0;
        busy       = (state_q != IDLE);
        done       = (state_q == DRAIN) && pop && head_end && !abort;
        count_d    = count_q + CW'(push) - CW'(pop);

        state_d = state_q;
        ptr_d   = imem_read_req ? ptr_q + ADDR_WIDTH'(1) : ptr_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = FETCH;
                ptr_d   = start_addr;
            end
            FETCH: if (push && ret_end) state_d = DRAIN;
            DRAIN: if (pop && head_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            inflight_q <= 1'b0;
            req_addr_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            inflight_q <= imem_read_req;
            if (imem_read_req) req_addr_q <= ptr_q;
            if (abort) begin
                wr_q    <= '0;
                rd_q    <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    fifo_data_q[wr_q] <= imem_read_data;
                    fifo_addr_q[wr_q] <= req_addr_q;
                    wr_q              <= wr_q + PW'(1);
                end
                if (pop) rd_q <= rd_q + PW'(1);
                count_q <= count_d;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a 1-cycle registered imem model.
module tb_inst_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, abort, inst_ready;
    logic [10:0] start_addr;
    logic        busy, done, imem_read_req, inst_valid;
    logic [10:0] imem_read_addr, inst_addr;
    logic [31:0] imem_read_data, inst_data;

    logic [31:0] mem [0:2047];
    int tests = 0, fails = 0;
    int req_cnt = 0, pop_cnt = 0, done_cnt = 0;
    logic [10:0] req_log [0:1023];
    logic [10:0] pop_addr [0:1023];
    logic [31:0] pop_data [0:1023];
    int b_req, b_pop, b_done;

    inst_fetch_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .abort(abort), .busy(busy), .done(done),
        .imem_read_req(imem_read_req), .imem_read_addr(imem_read_addr),
        .imem_read_data(imem_read_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_addr(inst_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_read_req) imem_read_data <= mem[imem_read_addr];

    always @(posedge clk) begin
        if (reset) begin
            if (imem_read_req) begin
                req_log[req_cnt[9:0]] <= imem_read_addr;
                req_cnt <= req_cnt + 1;
            end
            if (inst_valid && inst_ready) begin
                pop_addr[pop_cnt[9:0]] <= inst_addr;
                pop_data[pop_cnt[9:0]] <= inst_data;
                pop_cnt <= pop_cnt + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        b_req  = req_cnt;
        b_pop  = pop_cnt;
        b_done = done_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_read_data = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[11'h10] = 32'h1000_0001; mem[11'h11] = 32'h2000_0002;
        mem[11'h12] = 32'h3000_0003; mem[11'h13] = 32'hF000_0000;
        mem[11'h14] = 32'h5000_0005; mem[11'h15] = 32'h6000_0006;
        for (int i = 0; i < 16; i++) mem[11'h20 + i] = 32'h1000_0000 | i;
        mem[11'h7FE] = 32'h1000_0AAA; mem[11'h7FF] = 32'h2000_0BBB;
        mem[11'h000] = 32'hF000_0CCC; mem[11'h001] = 32'h3000_0001;
        mem[11'h50]  = 32'hF000_0000; mem[11'h51]  = 32'h1000_0051;

        reset = 1'b0; start = 1'b0; abort = 1'b0; inst_ready = 1'b0; start_addr = '0;
        step(); step();
        chk("rst_busy", busy, 0);  chk("rst_done", done, 0);
        chk("rst_req", imem_read_req, 0); chk("rst_valid", inst_valid, 0);
        chk("rst_raddr", imem_read_addr, 0); chk("rst_data", inst_data, 0);
        chk("rst_iaddr", inst_addr, 0);
        reset = 1'b1;

        // basic block, ready held high
        step(); mark(); start = 1; start_addr = 11'h10; inst_ready = 1; #1;
        step(); start = 0; #1;
        chk("b_c1_req", imem_read_req, 1); chk("b_c1_addr", imem_read_addr, 11'h10);
        chk("b_c1_valid", inst_valid, 0);
        step(); chk("b_c2_valid", inst_valid, 0); chk("b_c2_addr", imem_read_addr, 11'h11);
        step(); chk("b_c3_valid", inst_valid, 1); chk("b_c3_iaddr", inst_addr, 11'h10);
        chk("b_c3_data", inst_data, 32'h1000_0001); chk("b_c3_done", done, 0);
        step(); chk("b_c4_iaddr", inst_addr, 11'h11);
        step(); chk("b_c5_iaddr", inst_addr, 11'h12);
        step(); chk("b_c6_data", inst_data, 32'hF000_0000); chk("b_c6_done", done, 1);
        step(); chk("b_c7_busy", busy, 0); chk("b_c7_valid", inst_valid, 0);
        step(); step();
        chk("b_reqs", req_cnt - b_req, 5); chk("b_pops", pop_cnt - b_pop, 4);
        chk("b_dones", done_cnt - b_done, 1);

        // backpressure
        inst_ready = 0;
        step(); mark(); start = 1; start_addr = 11'h10; #1;
        step(); start = 0;
        step(); step(); chk("bp_c3_data", inst_data, 32'h1000_0001);
        repeat (7) step();
        chk("bp_c10_valid", inst_valid, 1); chk("bp_c10_data", inst_data, 32'h1000_0001);
        chk("bp_c10_iaddr", inst_addr, 11'h10); chk("bp_reqs", req_cnt - b_req, 4);
        chk("bp_c10_req", imem_read_req, 0); chk("bp_c10_done", done, 0);
        inst_ready = 1;
        repeat (6) step();
        chk("bp_pops", pop_cnt - b_pop, 4);
        for (int i = 0; i < 4; i++) chk("bp_order", pop_addr[b_pop + i], 11'h10 + i);
        chk("bp_data0", pop_data[b_pop], 32'h1000_0001);
        chk("bp_dones", done_cnt - b_done, 1); chk("bp_busy", busy, 0);

        // wrap-around
        step(); mark(); start = 1; start_addr = 11'h7FE; #1;
        step(); start = 0;
        repeat (9) step();
        chk("w_req0", req_log[b_req], 11'h7FE); chk("w_req1", req_log[b_req + 1], 11'h7FF);
        chk("w_req2", req_log[b_req + 2], 11'h000);
        chk("w_pops", pop_cnt - b_pop, 3);
        chk("w_pop2", pop_addr[b_pop + 2], 11'h000);
        chk("w_pdata2", pop_data[b_pop + 2], 32'hF000_0CCC);
        chk("w_dones", done_cnt - b_done, 1);

        // abort with 3 buffered and one in flight
        inst_ready = 0;
        step(); mark(); start = 1; start_addr = 11'h20; #1;
        step(); start = 0;
        repeat (4) step();
        chk("a_c5_valid", inst_valid, 1); chk("a_c5_req", imem_read_req, 0);
        abort = 1; #1;
        chk("a_c5_done", done, 0);
        step(); abort = 0; #1;
        chk("a_valid", inst_valid, 0); chk("a_busy", busy, 0);
        chk("a_done", done, 0); chk("a_req", imem_read_req, 0);
        mark(); inst_ready = 1; start = 1; start_addr = 11'h10; #1;
        step(); start = 0;
        repeat (8) step();
        chk("a_pops", pop_cnt - b_pop, 4); chk("a_pop0", pop_addr[b_pop], 11'h10);
        chk("a_pop3", pop_addr[b_pop + 3], 11'h13); chk("a_dones", done_cnt - b_done, 1);

        // reset mid-FETCH
        inst_ready = 0;
        step(); start = 1; start_addr = 11'h20; #1;
        step(); start = 0;
        step(); reset = 0;
        step(); reset = 1; #1;
        chk("r_busy", busy, 0); chk("r_done", done, 0);
        chk("r_req", imem_read_req, 0); chk("r_valid", inst_valid, 0);
        chk("r_raddr", imem_read_addr, 0); chk("r_data", inst_data, 0);
        chk("r_iaddr", inst_addr, 0);

        // start while busy is ignored
        step(); mark(); start = 1; start_addr = 11'h10; #1;
        step(); start = 0;
        step(); step(); start = 1; start_addr = 11'h40; #1;
        step(); start = 0;
        step(); step(); inst_ready = 1;
        repeat (8) step();
        chk("sb_pops", pop_cnt - b_pop, 4); chk("sb_pop0", pop_addr[b_pop], 11'h10);
        chk("sb_pop3", pop_addr[b_pop + 3], 11'h13); chk("sb_dones", done_cnt - b_done, 1);
        chk("sb_busy", busy, 0);

        // immediate end
        step(); mark(); start = 1; start_addr = 11'h50; #1;
        step(); start = 0;
        step(); step();
        chk("ie_valid", inst_valid, 1); chk("ie_data", inst_data, 32'hF000_0000);
        chk("ie_done", done, 1);
        step(); chk("ie_valid_after", inst_valid, 0); chk("ie_busy", busy, 0);
        repeat (4) step();
        chk("ie_pops", pop_cnt - b_pop, 1); chk("ie_dones", done_cnt - b_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
